// File: rtl/adc_acq_scheduler.sv
// Periodic ADC acquisition scheduler: paces trigger pulses and forwards
// host commands to the ADC SPI manager with priority and holdoff.
module adc_acq_scheduler #(
    parameter int CNT_W   = 32,
    parameter int OVR_W   = 16,
    parameter int HOLDOFF = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_num_samples,
    input  logic             adc_ready,
    output logic             trigger_acq,
    input  logic [31:0]      s_axis_cmd_tdata,
    input  logic             s_axis_cmd_tvalid,
    output logic             s_axis_cmd_tready,
    output logic [31:0]      m_axis_cmd_tdata,
    output logic             m_axis_cmd_tvalid,
    input  logic             m_axis_cmd_tready,
    input  logic             sample_valid,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [OVR_W-1:0] overrun_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] nsamp_q, nsamp_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             tick_due_q, tick_due_d;
    logic             cmd_full_q, cmd_full_d;
    logic [31:0]      cmd_data_q, cmd_data_d;
    logic             mvalid_q, mvalid_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic             hold_ok, cmd_elig, m_valid, m_hs, s_rdy, s_hs;
    logic             trig, wrap, issue, drain_done;
    logic [CNT_W-1:0] period_clamp;

    assign hold_ok      = (hold_q == '0);
    assign cmd_elig     = cmd_full_q & adc_ready & hold_ok;
    assign m_valid      = mvalid_q | cmd_elig;
    assign m_hs         = m_valid & m_axis_cmd_tready;
    assign s_rdy        = ~cmd_full_q & ~areset;
    assign s_hs         = s_axis_cmd_tvalid & s_rdy;
    // A buffered command always outranks a pending tick.
    assign trig         = (state_q == RUN) & tick_due_q & adc_ready
                        & hold_ok & ~cmd_full_q;
    assign wrap         = (state_q == RUN) & (pcnt_q == period_q - CNT_W'(1));
    assign issue        = trig | (cmd_elig & ~mvalid_q);
    assign drain_done   = (state_q == DRAIN) & (smp_cnt_q == trig_cnt_q);
    assign period_clamp = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;

    assign trigger_acq       = trig;
    assign s_axis_cmd_tready = s_rdy;
    assign m_axis_cmd_tvalid = m_valid;
    assign m_axis_cmd_tdata  = cmd_data_q;
    assign running           = (state_q != IDLE);
    assign done              = drain_done;
    assign sample_count      = smp_cnt_q;
    assign overrun_count     = ovr_q;

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        nsamp_d    = nsamp_q;
        pcnt_d     = pcnt_q;
        trig_cnt_d = trig_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        ovr_d      = ovr_q;
        tick_due_d = tick_due_q;
        cmd_full_d = cmd_full_q;
        cmd_data_d = cmd_data_q;
        mvalid_d   = m_valid & ~m_axis_cmd_tready;
        hold_d     = hold_q;

        if (issue)
            hold_d = HW'(HOLDOFF);
        else if (!hold_ok)
            hold_d = hold_q - HW'(1);

        if (m_hs)
            cmd_full_d = 1'b0;
        if (s_hs) begin
            cmd_full_d = 1'b1;
            cmd_data_d = s_axis_cmd_tdata;
        end

        if (state_q != IDLE && sample_valid)
            smp_cnt_d = smp_cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                pcnt_d = period_q - CNT_W'(1);
                if (start && !stop) begin
                    period_d   = period_clamp;
                    nsamp_d    = cfg_num_samples;
                    pcnt_d     = period_clamp - CNT_W'(1);
                    trig_cnt_d = '0;
                    smp_cnt_d  = '0;
                    ovr_d      = '0;
                    tick_due_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                pcnt_d = wrap ? '0 : pcnt_q + CNT_W'(1);
                if (trig)
                    tick_due_d = 1'b0;
                if (wrap) begin
                    tick_due_d = 1'b1;
                    // Ticks are never queued; a missed one is only counted.
                    if (tick_due_q && !trig && ovr_q != '1)
                        ovr_d = ovr_q + OVR_W'(1);
                end
                if (trig) begin
                    trig_cnt_d = trig_cnt_q + CNT_W'(1);
                    if (nsamp_q != '0 && trig_cnt_d == nsamp_q)
                        state_d = DRAIN;
                end
                if (stop) begin
                    tick_due_d = 1'b0;
                    state_d    = DRAIN;
                end
                if (state_d != RUN)
                    pcnt_d = period_q - CNT_W'(1);
            end
            DRAIN: begin
                pcnt_d = period_q - CNT_W'(1);
                if (drain_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            period_q   <= CNT_W'(2);
            nsamp_q    <= '0;
            pcnt_q     <= CNT_W'(1);
            trig_cnt_q <= '0;
            smp_cnt_q  <= '0;
            ovr_q      <= '0;
            tick_due_q <= 1'b0;
            cmd_full_q <= 1'b0;
            cmd_data_q <= '0;
            mvalid_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            nsamp_q    <= nsamp_d;
            pcnt_q     <= pcnt_d;
            trig_cnt_q <= trig_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            ovr_q      <= ovr_d;
            tick_due_q <= tick_due_d;
            cmd_full_q <= cmd_full_d;
            cmd_data_q <= cmd_data_d;
            mvalid_q   <= mvalid_d;
            hold_q     <= hold_d;
        end
    end

endmodule
